dmem_responder: RTL

- Data-memory responder that serves load/store requests issued by the core's MEM stage over a valid/ready request channel and a valid/ready response channel.
- Supports RV32I byte, halfword and word accesses, little-endian, with load sign/zero extension.
- Programmable wait states model slow memory.
- Flags misaligned, out-of-range and illegal-size requests instead of performing them.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channel bundle between the MEM stage and the data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data memory with wait states, byte lanes, load extension and error flagging
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input logic             CLK,
    input logic             RESET,
    dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] rd;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        err;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    // Decode the captured request: error check, lane selection, load extension, store lane enables
    always_comb begin
        idx  = addr_q[AW+1:2];
        word = mem[idx];
        b    = word[{addr_q[1:0], 3'b000} +: 8];
        h    = word[{addr_q[1], 4'b0000} +: 16];
        rd   = (size_q[1:0] == 2'b00) ? {{24{~size_q[2] & b[7]}}, b} :
               (size_q[1:0] == 2'b01) ? {{16{~size_q[2] & h[15]}}, h} : word;
        err  = (size_q == 3'b011) || (size_q[2:1] == 2'b11) || (we_q && size_q[2]) ||
               (size_q[1:0] == 2'b01 && addr_q[0]) ||
               (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) ||
               ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        be   = (size_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
               (size_q[1:0] == 2'b01) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
        wd   = (size_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
               (size_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
    end
    // Storage is written only in the single ACCESS cycle of an error-free store
    always_ff @(posedge CLK) begin
        if (state_q == S_ACCESS && we_q && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
    // Transaction FSM: capture, wait states, access, then hold the response until consumed
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    size_q  <= bus.req_size;
                    cnt_q   <= 4'(WAIT_CYCLES);
                    ready_q <= 1'b0;
                    state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    rdata_q <= (err || we_q) ? 32'h0 : rd;
                    err_q   <= err;
                    valid_q <= 1'b1;
                    state_q <= S_RESP;
                end
                default: if (bus.rsp_ready) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
